npn_eval_sequencer: RTL and testbench

NPN_EVAL_SEQUENCER -- requirements
Module: npn_eval_sequencer

---
 rtl/npn_eval_pkg.sv | 17 +
 rtl/onehot4_net.sv | 16 +
 rtl/npn_eval_sequencer.sv | 129 ++++++++++++
 tb/tb_npn_eval_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/npn_eval_pkg.sv
// Shared types and constants for the NPN truth-table evaluation sequencer.
// The optional input-permutation feature is enabled by the NPN_PERM_EN macro.
package npn_eval_pkg;

  localparam int TT_W  = 16;
  localparam int IDX_W = 4;

  // Truth table of the exactly-one-of-four function with identity NPN transform.
  localparam logic [TT_W-1:0] ONEHOT4_TT = 16'h0116;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    CHECK = 2'd2
  } state_e;

endpackage

// File: rtl/onehot4_net.sv
// Combinational network under evaluation: y0 is high when exactly one input is high.
module onehot4_net (
  input  logic x0,
  input  logic x1,
  input  logic x2,
  input  logic x3,
  output logic y0
);

  logic any_pair;

  // An odd count with no pair of ones set can only be a count of exactly one.
  assign any_pair = (x0 & x1) | (x0 & x2) | (x0 & x3) | (x1 & x2) | (x1 & x3) | (x2 & x3);
  assign y0       = (x0 ^ x1 ^ x2 ^ x3) & ~any_pair;

endmodule

// File: rtl/npn_eval_sequencer.sv
// Sweeps a 4-input network over all 16 input codes under a latched NPN transform and
// reports the captured truth table. Define NPN_PERM_EN to add the perm_i input permutation.
module npn_eval_sequencer
  import npn_eval_pkg::*;
#(
  parameter int CHECK_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [3:0]      neg_in_i,
  input  logic            neg_out_i,
  input  logic [TT_W-1:0] exp_tt_i,
`ifdef NPN_PERM_EN
  input  logic [7:0]      perm_i,
`endif
  output logic            busy_o,
  output logic            done_o,
  output logic [TT_W-1:0] tt_o,
  output logic            match_o,
  output state_e          dbg_state
);

  // Handshake: start_i is a level sampled only in IDLE while done_o is low and
  // abort_i is low; abort_i acts on the next edge in SWEEP or CHECK; done_o is a
  // single-cycle result strobe, with tt_o/match_o held until the next strobe.

  state_e             state, state_next;
  logic [IDX_W-1:0]   idx;
  logic [TT_W-1:0]    tt_acc;
  logic [3:0]         neg_in_q;
  logic               neg_out_q;
  logic [TT_W-1:0]    exp_q;
  logic [3:0]         neg_idx;
  logic [3:0]         x;
  logic               y;
  logic               start_ok;

`ifdef NPN_PERM_EN
  logic [7:0]         perm_q;
`endif

  assign start_ok  = (state == IDLE) && start_i && !done_o && !abort_i;
  assign busy_o    = (state == SWEEP) || (state == CHECK);
  assign dbg_state = state;
  assign neg_idx   = idx ^ neg_in_q;

  always_comb begin
    x = neg_idx;
`ifdef NPN_PERM_EN
    for (int k = 0; k < 4; k++) begin
      x[k] = neg_idx[perm_q[2*k +: 2]];
    end
`endif
  end

  onehot4_net u_net (
    .x0 (x[0]),
    .x1 (x[1]),
    .x2 (x[2]),
    .x3 (x[3]),
    .y0 (y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = SWEEP;
      SWEEP:   if (abort_i) state_next = IDLE;
               else if (idx == IDX_W'(TT_W - 1)) state_next = CHECK;
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      tt_acc    <= '0;
      neg_in_q  <= '0;
      neg_out_q <= 1'b0;
      exp_q     <= '0;
`ifdef NPN_PERM_EN
      perm_q    <= '0;
`endif
      done_o    <= 1'b0;
      tt_o      <= '0;
      match_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            idx       <= '0;
            tt_acc    <= '0;
            neg_in_q  <= neg_in_i;
            neg_out_q <= neg_out_i;
            exp_q     <= exp_tt_i;
`ifdef NPN_PERM_EN
            perm_q    <= perm_i;
`endif
          end
        end
        SWEEP: begin
          if (!abort_i) begin
            tt_acc[idx] <= y ^ neg_out_q;
            idx         <= idx + 1'b1;
          end
        end
        CHECK: begin
          // tt_o is only ever loaded from a completed sweep.
          if (!abort_i) begin
            tt_o    <= tt_acc;
            match_o <= (CHECK_EN != 0) && (tt_acc == exp_q);
            done_o  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_npn_eval_sequencer.sv
// Self-checking bench for npn_eval_sequencer: directed NPN cases, random configurations,
// abort, asynchronous reset mid-sweep and start pulses while busy.
module tb_npn_eval_sequencer;
  import npn_eval_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  neg_in = '0;
  logic        neg_out = 1'b0;
  logic [15:0] exp_tt_in = '0;
  logic [7:0]  perm = 8'b11_10_01_00;
  logic        busy, done, match;
  logic [15:0] tt;
  state_e      dbg_state;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  npn_eval_sequencer #(.CHECK_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .abort_i   (abort),
    .neg_in_i  (neg_in),
    .neg_out_i (neg_out),
    .exp_tt_i  (exp_tt_in),
`ifdef NPN_PERM_EN
    .perm_i    (perm),
`endif
    .busy_o    (busy),
    .done_o    (done),
    .tt_o      (tt),
    .match_o   (match),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Reference: y = "exactly one of x is set", x_k = (i ^ neg_in) bit selected by perm.
  function automatic logic [15:0] model_tt(logic [3:0] ni, logic no, logic [7:0] pm);
    logic [15:0] r;
    logic [3:0]  v, xv;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      v  = 4'(i) ^ ni;
      xv = v;
`ifdef NPN_PERM_EN
      for (int k = 0; k < 4; k++) xv[k] = v[pm[2*k +: 2]];
`endif
      r[i] = ($countones(xv) == 1) ^ no;
    end
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Start at a negedge, scramble inputs during the sweep, check busy/done timing and result.
  task automatic run_sweep(input logic [3:0] ni, input logic no, input logic [15:0] ex,
                           input logic [7:0] pm, input string name);
    logic [15:0] want;
    @(negedge clk);
    neg_in = ni; neg_out = no; exp_tt_in = ex; perm = pm; start = 1'b1;
    exp_q.push_back(model_tt(ni, no, pm));
    @(negedge clk);
    start = 1'b0;
    neg_in = 4'($urandom); neg_out = 1'($urandom);
    exp_tt_in = 16'($urandom); perm = 8'($urandom);
    for (int c = 1; c <= 17; c++) begin
      if (c > 1) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_window cycle %0d: busy=%b done=%b required busy=1 done=0",
                 name, c, busy, done);
      end
    end
    @(negedge clk);
    want = exp_q.pop_front();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_cycle18: done=%b busy=%b required done=1 busy=0", name, done, busy);
    end
    checks++;
    if (tt !== want) begin
      errors++;
      $display("FAIL %s tt_o: got %h required %h", name, tt, want);
    end
    checks++;
    if (match !== (want == ex)) begin
      errors++;
      $display("FAIL %s match_o: got %b required %b", name, match, (want == ex));
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || tt !== 16'h0000 || match !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b tt=%h match=%b state=%0d required all 0",
               busy, done, tt, match, dbg_state);
    end
  endtask

  task automatic test_directed();
    run_sweep(4'b0000, 1'b0, ONEHOT4_TT, 8'b11_10_01_00, "identity");
    checks++;
    if (tt !== 16'h0116 || match !== 1'b1) begin
      errors++;
      $display("FAIL identity_golden: tt=%h match=%b required 0116 1", tt, match);
    end
    run_sweep(4'b0000, 1'b1, ONEHOT4_TT, 8'b11_10_01_00, "neg_out");
    checks++;
    if (tt !== 16'hFEE9 || match !== 1'b0) begin
      errors++;
      $display("FAIL neg_out_golden: tt=%h match=%b required fee9 0", tt, match);
    end
    run_sweep(4'b1111, 1'b0, 16'h6880, 8'b11_10_01_00, "neg_in_all");
    checks++;
    if (tt !== 16'h6880 || match !== 1'b1) begin
      errors++;
      $display("FAIL neg_in_all_golden: tt=%h match=%b required 6880 1", tt, match);
    end
    run_sweep(4'b0001, 1'b0, ONEHOT4_TT, 8'b11_10_01_00, "neg_in_x0");
    checks++;
    if (tt !== 16'h0229) begin
      errors++;
      $display("FAIL neg_in_x0_golden: tt=%h required 0229", tt);
    end
`ifdef NPN_PERM_EN
    run_sweep(4'b0000, 1'b0, ONEHOT4_TT, 8'b00_01_10_11, "perm_reverse");
    checks++;
    if (tt !== 16'h0116 || match !== 1'b1) begin
      errors++;
      $display("FAIL perm_reverse_golden: tt=%h match=%b required 0116 1", tt, match);
    end
`endif
  endtask

  task automatic test_random();
    logic [3:0]  ni;
    logic        no;
    logic [7:0]  pm;
    logic [15:0] ex;
    for (int n = 0; n < 10; n++) begin
      ni = 4'($urandom);
      no = 1'($urandom);
      pm = 8'b11_10_01_00;
`ifdef NPN_PERM_EN
      pm = 8'($urandom);
`endif
      ex = ($urandom_range(0, 1) == 1) ? model_tt(ni, no, pm) : 16'($urandom);
      run_sweep(ni, no, ex, pm, "random");
    end
  endtask

  task automatic test_back_to_back();
    run_sweep(4'b0010, 1'b0, ONEHOT4_TT, 8'b11_10_01_00, "b2b_first");
    run_sweep(4'b0100, 1'b1, ONEHOT4_TT, 8'b11_10_01_00, "b2b_second");
  endtask

  task automatic test_abort();
    int dones;
    run_sweep(4'b0000, 1'b0, ONEHOT4_TT, 8'b11_10_01_00, "pre_abort");
    @(negedge clk);
    neg_in = 4'b1111; neg_out = 1'b1; exp_tt_in = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b required 0", busy);
    end
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones != 0 || tt !== 16'h0116 || match !== 1'b1) begin
      errors++;
      $display("FAIL abort_hold: dones=%0d tt=%h match=%b required 0 0116 1", dones, tt, match);
    end
    run_sweep(4'b1000, 1'b0, ONEHOT4_TT, 8'b11_10_01_00, "post_abort");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    neg_in = 4'b0000; neg_out = 1'b0; exp_tt_in = ONEHOT4_TT; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || tt !== 16'h0000 || match !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_mid_async: busy=%b done=%b tt=%h match=%b required all 0",
               busy, done, tt, match);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: busy=%b done=%b required 0 0", busy, done);
    end
    run_sweep(4'b0000, 1'b0, ONEHOT4_TT, 8'b11_10_01_00, "post_reset");
  endtask

  task automatic test_start_while_busy();
    int dones;
    logic [15:0] want;
    @(negedge clk);
    neg_in = 4'b0011; neg_out = 1'b0; exp_tt_in = ONEHOT4_TT; start = 1'b1;
    want = model_tt(4'b0011, 1'b0, 8'b11_10_01_00);
    @(negedge clk);
    dones = 0;
    for (int c = 1; c <= 25; c++) begin
      if (c > 1) @(negedge clk);
      if (done === 1'b1) dones++;
      if (c == 19) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL start_on_done_ignored: busy=%b required 0", busy);
        end
      end
      neg_in = 4'($urandom);
      start = (c <= 17) ? 1'($urandom_range(0, 1)) : (c == 18);
    end
    start = 1'b0;
    checks++;
    if (dones != 1 || tt !== want) begin
      errors++;
      $display("FAIL start_while_busy: dones=%0d tt=%h required 1 %h", dones, tt, want);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_start_while_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
